// File: rtl/ysyx_25030093_csr_pkg.sv
// Purpose: shared CSR addresses, mstatus field positions and cause codes for the CSR file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ysyx_25030093_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MSTATUS_MPP_LO = 11;

    // Only MIE and MPIE are software-writable; MPP is hardwired to machine mode.
    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [31:0] MSTATUS_MPP_M = 32'h0000_1800;

    localparam logic [31:0] CAUSE_ECALL_M = 32'd11;

    // Addresses that accept a software write (the ID registers are read-only).
    function automatic logic csr_is_writable(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_25030093_csr_counter64.sv
// Purpose: 64-bit free-running/event counter with independent software-writable halves.
// Latency: write or increment visible on q the cycle after the edge that applies it.
// Backpressure: none; a write to either half suppresses that cycle's increment.
// Ports: clk, rst (sync, active-high), inc, wen_lo, wen_hi, wdata[31:0], q[63:0].
module ysyx_25030093_csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wen_lo,
    input  logic        wen_hi,
    input  logic [31:0] wdata,
    output logic [63:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (wen_lo || wen_hi) begin
            // The half not being written holds its value; no increment this cycle.
            if (wen_lo) q[31:0]  <= wdata;
            if (wen_hi) q[63:32] <= wdata;
        end else if (inc) begin
            q <= q + 64'd1;
        end
    end

endmodule

// File: rtl/ysyx_25030093_csr_file.sv
// Purpose: machine-mode CSR file with ecall/mret state updates, trap redirect and mcycle/minstret.
// Latency: reads and trap redirect are combinational; writes visible the cycle after csr_wen.
// Backpressure: none; every input is acted on in the cycle it is presented.
// Ports: clk, rst; csr_raddr -> csr_data/csr_illegal; csr_wen/csr_waddr/csr_wdata write port;
//        ecall, mret, pc, inst_retire retirement inputs; trap_valid/trap_pc to fetch.
module ysyx_25030093_csr_file
    import ysyx_25030093_csr_pkg::*;
#(
    parameter logic [31:0] MVENDORID   = 32'h7973_7978,
    parameter logic [31:0] MARCHID     = 32'h017D_EDCD,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] csr_raddr,
    output logic [31:0] csr_data,
    output logic        csr_illegal,
    input  logic        csr_wen,
    input  logic [11:0] csr_waddr,
    input  logic [31:0] csr_wdata,
    input  logic        ecall,
    input  logic        mret,
    input  logic [31:0] pc,
    input  logic        inst_retire,
    output logic        trap_valid,
    output logic [31:0] trap_pc
);

    // mstatus_q holds only the writable bits (MIE/MPIE); MPP is OR-ed in on read.
    logic [31:0] mstatus_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;

    logic        wr_req;
    logic        rd_valid;

    // A trap in the same cycle swallows the software write completely.
    assign wr_req = csr_wen && !ecall && !mret;

    always_comb begin
        csr_data = '0;
        rd_valid = 1'b1;
        case (csr_raddr)
            CSR_MSTATUS:   csr_data = mstatus_q | MSTATUS_MPP_M;
            CSR_MTVEC:     csr_data = mtvec_q;
            CSR_MSCRATCH:  csr_data = mscratch_q;
            CSR_MEPC:      csr_data = mepc_q;
            CSR_MCAUSE:    csr_data = mcause_q;
            CSR_MCYCLE:    csr_data = mcycle_q[31:0];
            CSR_MCYCLEH:   csr_data = mcycle_q[63:32];
            CSR_MINSTRET:  csr_data = minstret_q[31:0];
            CSR_MINSTRETH: csr_data = minstret_q[63:32];
            CSR_MVENDORID: csr_data = MVENDORID;
            CSR_MARCHID:   csr_data = MARCHID;
            default:       rd_valid = 1'b0;
        endcase
    end

    assign csr_illegal = !rd_valid || (wr_req && !csr_is_writable(csr_waddr));

    assign trap_valid = ecall || mret;
    assign trap_pc    = ecall ? mtvec_q : (mret ? mepc_q : 32'h0);

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q  <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else if (ecall) begin
            mepc_q                 <= {pc[31:2], 2'b00};
            mcause_q               <= CAUSE_ECALL_M;
            mstatus_q[MSTATUS_MPIE] <= mstatus_q[MSTATUS_MIE];
            mstatus_q[MSTATUS_MIE]  <= 1'b0;
        end else if (mret) begin
            mstatus_q[MSTATUS_MIE]  <= mstatus_q[MSTATUS_MPIE];
            mstatus_q[MSTATUS_MPIE] <= 1'b1;
        end else if (wr_req) begin
            case (csr_waddr)
                CSR_MSTATUS:  mstatus_q  <= csr_wdata & MSTATUS_WMASK;
                CSR_MTVEC:    mtvec_q    <= {csr_wdata[31:2], 2'b00};
                CSR_MSCRATCH: mscratch_q <= csr_wdata;
                CSR_MEPC:     mepc_q     <= {csr_wdata[31:2], 2'b00};
                CSR_MCAUSE:   mcause_q   <= csr_wdata;
                default:      ;
            endcase
        end
    end

    ysyx_25030093_csr_counter64 u_mcycle (
        .clk    (clk),
        .rst    (rst),
        .inc    (1'b1),
        .wen_lo (wr_req && (csr_waddr == CSR_MCYCLE)),
        .wen_hi (wr_req && (csr_waddr == CSR_MCYCLEH)),
        .wdata  (csr_wdata),
        .q      (mcycle_q)
    );

    ysyx_25030093_csr_counter64 u_minstret (
        .clk    (clk),
        .rst    (rst),
        .inc    (inst_retire),
        .wen_lo (wr_req && (csr_waddr == CSR_MINSTRET)),
        .wen_hi (wr_req && (csr_waddr == CSR_MINSTRETH)),
        .wdata  (csr_wdata),
        .q      (minstret_q)
    );

endmodule
